instr_fetch: RTL and testbench

Instruction fetch and field-split stage of the RISC-V core, upstream of the control unit. It holds the program counter and requests 32-bit words from instruction memory over a req/ack handshake. Each word is latched into an instruction register and split into opcode, funct3, funct7 and register indices. It presents the result with a valid/ready handshake to the decode/control stage and accepts a PC redirect from the execute path.

---
 rtl/instr_fetch_pkg.sv | 32 +++
 rtl/instr_fetch_fields.sv | 20 ++
 rtl/instr_fetch.sv | 154 +++++++++++++++
 tb/tb_instr_fetch.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared opcode constants, NOP encoding and fetch FSM states.
// Used by the fetch stage and the control unit.
package instr_fetch_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        VALID,
        HALT
    } fetch_state_e;

    // True for the opcodes this core implements.
    function automatic logic op_supported(input logic [6:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE, OP_STORE, OP_LUI, OP_IMM, OP_LOAD: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_fetch_fields.sv
// Combinational slicer of a 32-bit instruction into its fields.
// No sign extension; later stages reuse this block.
module instr_fields (
    input  logic [31:0] instr_i,
    output logic [6:0]  opcode_o,
    output logic [2:0]  funct3_o,
    output logic [6:0]  funct7_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o
);

    assign opcode_o = instr_i[6:0];
    assign rd_o     = instr_i[11:7];
    assign funct3_o = instr_i[14:12];
    assign rs1_o    = instr_i[19:15];
    assign rs2_o    = instr_i[24:20];
    assign funct7_o = instr_i[31:25];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, imem req/ack, instruction register.
// Optional ILLEGAL_OP_TRAP_EN halts on unsupported opcodes.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                     PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                dec_ready,
    output logic                instr_valid,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [6:0]          opcode,
    output logic [2:0]          funct3,
    output logic [6:0]          funct7,
    output logic [4:0]          rd,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic                illegal
);

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);
    localparam logic [PC_WIDTH-1:0] RESET_AL   = RESET_PC & ALIGN_MASK;

    fetch_state_e        state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] addr_q;
    logic [PC_WIDTH-1:0] pc_out_q;
    logic [31:0]         instr_q;
    logic                req_q;
    logic                valid_q;
    logic                illegal_q;

    logic [PC_WIDTH-1:0] redir_pc_d;
    logic [PC_WIDTH-1:0] pc_inc_d;
    logic                trap_d;

    assign redir_pc_d = redirect_pc & ALIGN_MASK;
    assign pc_inc_d   = pc_q + PC_WIDTH'(4);

`ifdef ILLEGAL_OP_TRAP_EN
    assign trap_d = !op_supported(imem_rdata[6:0]);
`else
    assign trap_d = 1'b0;
`endif

    // Fetch FSM: PC, request address and instruction register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_AL;
            addr_q    <= RESET_AL;
            pc_out_q  <= RESET_AL;
            instr_q   <= NOP_INSTR;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                    if (redirect_valid) begin
                        pc_q   <= redir_pc_d;
                        addr_q <= redir_pc_d;
                    end else begin
                        addr_q <= pc_q;
                    end
                end
                FETCH: begin
                    if (redirect_valid) begin
                        pc_q <= redir_pc_d;
                        if (imem_ack) begin
                            // Word discarded; restart at target.
                            addr_q <= redir_pc_d;
                        end else begin
                            // Old request must still complete.
                            state_q <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        instr_q  <= imem_rdata;
                        pc_out_q <= pc_q;
                        req_q    <= 1'b0;
                        if (trap_d) begin
                            illegal_q <= 1'b1;
                            state_q   <= HALT;
                        end else begin
                            pc_q    <= pc_inc_d;
                            valid_q <= 1'b1;
                            state_q <= VALID;
                        end
                    end
                end
                DRAIN: begin
                    if (redirect_valid) begin
                        pc_q <= redir_pc_d;
                    end
                    if (imem_ack) begin
                        state_q <= FETCH;
                        addr_q  <= redirect_valid ? redir_pc_d : pc_q;
                    end
                end
                VALID: begin
                    if (redirect_valid || dec_ready) begin
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= FETCH;
                        if (redirect_valid) begin
                            pc_q   <= redir_pc_d;
                            addr_q <= redir_pc_d;
                        end else begin
                            addr_q <= pc_q;
                        end
                    end
                end
                HALT: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign illegal     = illegal_q;

    instr_fields u_fields (
        .instr_i  (instr_q),
        .opcode_o (opcode),
        .funct3_o (funct3),
        .funct7_o (funct7),
        .rd_o     (rd),
        .rs1_o    (rs1),
        .rs2_o    (rs2)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: vector table plus
// hand-written redirect, wrap, illegal-opcode and reset sequences.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] word;
        int          lat;
        int          stall;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        vec_t        v;
    } exp_t;

    vec_t vt[6];
    exp_t sb[$];

    instr_fetch #(
        .PC_WIDTH (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_ready      (dec_ready),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .pc_out         (pc_out),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7),
        .rd             (rd),
        .rs1            (rs1),
        .rs2            (rs2),
        .illegal        (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] w, input int lat,
                                 input int stall, input logic [6:0] op,
                                 input logic [4:0] d, input logic [4:0] s1,
                                 input logic [4:0] s2, input logic [2:0] f3,
                                 input logic [6:0] f7);
        vec_t v;
        v.word = w; v.lat = lat; v.stall = stall;
        v.op = op; v.rd = d; v.rs1 = s1; v.rs2 = s2;
        v.f3 = f3; v.f7 = f7;
        return v;
    endfunction

    // Wait for a request at address a, ack after lat cycles with v.word.
    task automatic serve(input logic [31:0] a, input vec_t v,
                         input bit push);
        int   n;
        logic ok;
        exp_t e;
        n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", {31'd0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, a);
        ok = 1'b1;
        repeat (v.lat) begin
            @(negedge clk);
            if (imem_req !== 1'b1 || imem_addr !== a || instr_valid !== 1'b0)
                ok = 1'b0;
        end
        if (v.lat > 0) chk("req_stable", {31'd0, ok}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = v.word;
        if (push) begin
            e.pc = a;
            e.v  = v;
            sb.push_back(e);
        end
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
    endtask

    // Wait for instr_valid, stall, then accept and compare.
    task automatic consume(input int stall);
        int   n;
        logic ok;
        exp_t e;
        n = 0;
        while (instr_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("valid_lat", n, 32'd0);
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL sb_underflow: got 0 entries want 1");
            return;
        end
        e  = sb[0];
        ok = 1'b1;
        repeat (stall) begin
            if (instr_valid !== 1'b1 || instr !== e.v.word || pc_out !== e.pc)
                ok = 1'b0;
            @(negedge clk);
        end
        if (stall > 0) chk("stall_hold", {31'd0, ok}, 32'd1);
        dec_ready = 1'b1;
        e = sb.pop_front();
        chk("valid",   {31'd0, instr_valid}, 32'd1);
        chk("instr",   instr, e.v.word);
        chk("pc_out",  pc_out, e.pc);
        chk("opcode",  {25'd0, opcode}, {25'd0, e.v.op});
        chk("rd",      {27'd0, rd}, {27'd0, e.v.rd});
        chk("rs1",     {27'd0, rs1}, {27'd0, e.v.rs1});
        chk("rs2",     {27'd0, rs2}, {27'd0, e.v.rs2});
        chk("funct3",  {29'd0, funct3}, {29'd0, e.v.f3});
        chk("funct7",  {25'd0, funct7}, {25'd0, e.v.f7});
        chk("illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        dec_ready = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_op",    {25'd0, opcode}, 32'h13);
        chk("rst_pcout", pc_out, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_ill",   {31'd0, illegal}, 32'd0);
    endtask

    initial begin
        vec_t v7f;
        logic ok;
        vt[0] = mkv(32'h0020_8033, 0, 0, 7'h33, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00);
        vt[1] = mkv(32'h4031_5233, 3, 5, 7'h33, 5'd4, 5'd2, 5'd3, 3'd5, 7'h20);
        vt[2] = mkv(32'h1234_52B7, 1, 0, 7'h37, 5'd5, 5'd8, 5'd3, 3'd5, 7'h09);
        vt[3] = mkv(32'hFFF0_8093, 0, 2, 7'h13, 5'd1, 5'd1, 5'd31, 3'd0, 7'h7F);
        vt[4] = mkv(32'h0081_2303, 2, 0, 7'h03, 5'd6, 5'd2, 5'd8, 3'd2, 7'h00);
        vt[5] = mkv(32'h0011_2423, 0, 1, 7'h23, 5'd8, 5'd2, 5'd1, 3'd2, 7'h00);
        v7f   = mkv(32'h0000_007F, 0, 0, 7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00);

        rst            = 1'b1;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            serve(32'(i * 4), vt[i], 1'b1);
            consume(vt[i].stall);
        end

        // Redirect in FETCH, ack two cycles later: word drained.
        serve_wait_24: begin
            int n;
            n = 0;
            while (imem_req !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        chk("a_addr0", imem_addr, 32'd24);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("a_drain_addr", imem_addr, 32'd24);
        chk("a_drain_req", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0050_0093;
        chk("a_drain_addr2", imem_addr, 32'd24);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("a_new_addr", imem_addr, 32'h100);
        chk("a_no_valid", {31'd0, instr_valid}, 32'd0);
        serve(32'h100, vt[0], 1'b1);
        consume(0);

        // Redirect in the same cycle as ack: word discarded.
        chk("b_addr0", imem_addr, 32'h104);
        imem_ack       = 1'b1;
        imem_rdata     = 32'h0030_0093;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        chk("b_no_valid", {31'd0, instr_valid}, 32'd0);
        chk("b_new_addr", imem_addr, 32'h200);
        @(negedge clk);
        chk("b_no_valid2", {31'd0, instr_valid}, 32'd0);
        serve(32'h200, vt[1], 1'b1);
        consume(vt[1].stall);

        // Redirect in VALID with dec_ready=1: drop, wrap to 0xFFFFFFFC.
        serve(32'h204, vt[2], 1'b0);
        chk("c_valid", {31'd0, instr_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        dec_ready      = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        dec_ready      = 1'b0;
        chk("c_dropped", {31'd0, instr_valid}, 32'd0);
        chk("c_addr", imem_addr, 32'hFFFF_FFFC);
        serve(32'hFFFF_FFFC, vt[3], 1'b1);
        consume(0);

        // Unsupported opcode at the wrapped address 0.
`ifdef ILLEGAL_OP_TRAP_EN
        serve(32'h0, v7f, 1'b0);
        chk("e_illegal", {31'd0, illegal}, 32'd1);
        chk("e_req", {31'd0, imem_req}, 32'd0);
        chk("e_valid", {31'd0, instr_valid}, 32'd0);
        chk("e_instr", instr, 32'h0000_007F);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        ok = 1'b1;
        repeat (4) begin
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || illegal !== 1'b1)
                ok = 1'b0;
            @(negedge clk);
        end
        chk("e_halt_hold", {31'd0, ok}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("e_ill_clear", {31'd0, illegal}, 32'd0);
        serve(32'h0, vt[4], 1'b1);
        consume(0);
`else
        serve(32'h0, v7f, 1'b1);
        consume(0);
`endif

        // Reset while waiting for ack, then a late ack.
        serve_wait_f: begin
            int n;
            n = 0;
            while (imem_req !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        chk("f_addr0", imem_addr, 32'h4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals();
        imem_ack   = 1'b1;
        imem_rdata = 32'h00A0_0093;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("f_valid", {31'd0, instr_valid}, 32'd0);
        chk("f_restart", imem_addr, 32'h0);
        serve(32'h0, vt[5], 1'b1);
        consume(0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
